// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the register file's single write port between the pipeline's
// writeback stage and an out-of-band multiply/divide unit (MDU).
//   * Pipeline writes always get the port, with no added latency.
//   * MDU results are queued in a small FIFO and drained on idle port cycles.
//   * With WB_ARB_STARVE_EN defined, a head entry that has been refused the
//     port for STARVE_LIMIT cycles forces a one-cycle W-stage hold (Stall_o)
//     during which it drains. Without the macro Stall_o is tied low and the
//     FSM only has IDLE/WAIT.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   RegWriteW_i, RdW_i, ResultW_i     pipeline W-stage write request
//   MduValid_i, MduRd_i, MduData_i    MDU result offer
//   MduReady_o                        FIFO not full (push accepted when high)
//   RegWrite_o, WriteAddr_o,
//   WriteData_o                       register file write port
//   Stall_o                           registered W-stage hold request
//   PendingMask_o                     one-hot OR of live buffered rd targets
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteW_i,
    input  logic [4:0]            RdW_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic                  MduValid_i,
    input  logic [4:0]            MduRd_i,
    input  logic [DATA_WIDTH-1:0] MduData_i,
    output logic                  MduReady_o,
    output logic                  RegWrite_o,
    output logic [4:0]            WriteAddr_o,
    output logic [DATA_WIDTH-1:0] WriteData_o,
    output logic                  Stall_o,
    output logic [31:0]           PendingMask_o
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(BUF_DEPTH);

    // FIFO storage; rd/data need no reset because live_reg/count_reg
    // qualify every read of them.
    logic [4:0]            rd_mem   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  live_reg, live_next;
    logic [AW-1:0]         head_reg, tail_reg;
    logic [CW-1:0]         count_reg, count_next;

    logic pipe_req, pipe_grant, head_grant, pop, enq, fifo_empty, stall;
    logic head_live;

`ifdef WB_ARB_STARVE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_FORCE = 2'd2} state_t;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_reg, starve_next;
`else
    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
`endif
    state_t state_reg, state_next;

`ifdef WB_ARB_STARVE_EN
    assign stall = (state_reg == ST_FORCE);
`else
    assign stall = 1'b0;
`endif

    assign fifo_empty = (count_reg == '0);
    assign MduReady_o = (count_reg != FULL_COUNT);
    // rd 0 results complete the handshake but are dropped.
    assign enq        = MduValid_i && MduReady_o && (MduRd_i != 5'd0);
    assign pipe_req   = RegWriteW_i && (RdW_i != 5'd0);
    assign pipe_grant = !stall && pipe_req;
    // During a forced drain the FIFO is never empty (FORCE is only entered
    // from WAIT without a pop), so the head is always valid here.
    assign head_grant = stall || (!pipe_req && !fifo_empty);
    assign pop        = head_grant;
    assign head_live  = live_reg[head_reg];
    assign Stall_o    = stall;

    assign count_next = count_reg + CW'(enq) - CW'(pop);

    // Write port mux; a dead head still pops but writes nothing, and the
    // address/data are zeroed whenever no write is issued.
    always_comb begin
        RegWrite_o  = 1'b0;
        WriteAddr_o = 5'd0;
        WriteData_o = '0;
        if (pipe_grant) begin
            RegWrite_o  = 1'b1;
            WriteAddr_o = RdW_i;
            WriteData_o = ResultW_i;
        end else if (head_grant && head_live) begin
            RegWrite_o  = 1'b1;
            WriteAddr_o = rd_mem[head_reg];
            WriteData_o = data_mem[head_reg];
        end
    end

    // Per-entry liveness. A granted pipeline write to the same rd kills any
    // buffered entry for it, including one being pushed this very cycle:
    // the pipeline write is always the architecturally younger one.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_live
        logic kill;
        logic popped;
        logic pushed;
        assign kill   = pipe_grant && (rd_mem[gi] == RdW_i);
        assign popped = pop && (head_reg == AW'(gi));
        assign pushed = enq && (tail_reg == AW'(gi));
        assign live_next[gi] = pushed ? !(pipe_grant && (MduRd_i == RdW_i))
                                      : (live_reg[gi] && !kill && !popped);
    end

    always_comb begin
        PendingMask_o = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (live_reg[i]) begin
                PendingMask_o[rd_mem[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[tail_reg]   <= MduRd_i;
            data_mem[tail_reg] <= MduData_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_reg  <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            live_reg  <= live_next;
            count_reg <= count_next;
            if (pop) head_reg <= head_reg + AW'(1);
            if (enq) tail_reg <= tail_reg + AW'(1);
        end
    end

    // FSM next state. The starvation counter counts WAIT cycles in which the
    // head was refused the port; reaching STARVE_LIMIT schedules FORCE.
    always_comb begin
        state_next = state_reg;
`ifdef WB_ARB_STARVE_EN
        starve_next = starve_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (enq) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_next == '0) begin
                    state_next = ST_IDLE;
`ifdef WB_ARB_STARVE_EN
                    starve_next = '0;
                end else if (pop) begin
                    starve_next = '0;
                end else if (starve_reg == SW'(STARVE_LIMIT - 1)) begin
                    starve_next = SW'(STARVE_LIMIT);
                    state_next  = ST_FORCE;
                end else begin
                    starve_next = starve_reg + SW'(1);
`endif
                end
            end
`ifdef WB_ARB_STARVE_EN
            ST_FORCE: begin
                starve_next = '0;
                state_next  = (count_next == '0) ? ST_IDLE : ST_WAIT;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
`ifdef WB_ARB_STARVE_EN
            starve_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
`ifdef WB_ARB_STARVE_EN
            starve_reg <= starve_next;
`endif
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed scenarios followed by random traffic, every cycle compared against
// a queue-based reference model of the write-port arbitration rules.
// Optional starvation behaviour follows WB_ARB_STARVE_EN.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          RegWriteW_i;
    logic [4:0]    RdW_i;
    logic [DW-1:0] ResultW_i;
    logic          MduValid_i;
    logic [4:0]    MduRd_i;
    logic [DW-1:0] MduData_i;
    logic          MduReady_o;
    logic          RegWrite_o;
    logic [4:0]    WriteAddr_o;
    logic [DW-1:0] WriteData_o;
    logic          Stall_o;
    logic [31:0]   PendingMask_o;

    wb_port_arbiter #(
        .DATA_WIDTH  (DW),
        .BUF_DEPTH   (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegWriteW_i  (RegWriteW_i),
        .RdW_i        (RdW_i),
        .ResultW_i    (ResultW_i),
        .MduValid_i   (MduValid_i),
        .MduRd_i      (MduRd_i),
        .MduData_i    (MduData_i),
        .MduReady_o   (MduReady_o),
        .RegWrite_o   (RegWrite_o),
        .WriteAddr_o  (WriteAddr_o),
        .WriteData_o  (WriteData_o),
        .Stall_o      (Stall_o),
        .PendingMask_o(PendingMask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
        bit            live;
    } ent_t;

    ent_t q[$];
    int   wait_cnt;
    bit   force_flag;

    logic          e_we, e_stall, e_ready;
    logic [4:0]    e_addr;
    logic [DW-1:0] e_data;
    logic [31:0]   e_mask;
    bit            m_pop, m_pipe;

    task automatic model_reset();
        q.delete();
        wait_cnt   = 0;
        force_flag = 0;
    endtask

    task automatic model_eval();
        e_stall = force_flag;
        e_ready = (q.size() < DEPTH);
        e_we = 0; e_addr = 0; e_data = 0;
        m_pop = 0; m_pipe = 0;
        if (force_flag && q.size() > 0) begin
            m_pop = 1;
            if (q[0].live) begin e_we = 1; e_addr = q[0].rd; e_data = q[0].data; end
        end else if (RegWriteW_i && RdW_i != 0) begin
            m_pipe = 1;
            e_we = 1; e_addr = RdW_i; e_data = ResultW_i;
        end else if (q.size() > 0) begin
            m_pop = 1;
            if (q[0].live) begin e_we = 1; e_addr = q[0].rd; e_data = q[0].data; end
        end
        e_mask = 0;
        foreach (q[i]) if (q[i].live) e_mask[q[i].rd] = 1'b1;
    endtask

    task automatic model_update();
        int   sz0;
        ent_t e;
        sz0 = q.size();
        if (m_pipe) foreach (q[i]) if (q[i].rd == RdW_i) q[i].live = 0;
        if (m_pop) void'(q.pop_front());
        if (MduValid_i && e_ready && MduRd_i != 0) begin
            e.rd = MduRd_i; e.data = MduData_i;
            e.live = !(m_pipe && MduRd_i == RdW_i);
            q.push_back(e);
        end
        if (STARVE_EN) begin
            if (force_flag) begin
                force_flag = 0; wait_cnt = 0;
            end else if (sz0 == 0 || m_pop) begin
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt == LIMIT) begin force_flag = 1; wait_cnt = 0; end
            end
        end
    endtask

    task automatic compare_all();
        check("regwrite", RegWrite_o, e_we);
        check("addr", WriteAddr_o, e_addr);
        check("data", WriteData_o, e_data);
        check("stall", Stall_o, e_stall);
        check("ready", MduReady_o, e_ready);
        check("mask", PendingMask_o, e_mask);
    endtask

    // One clock cycle: called at posedge+1, drives, checks at posedge+3,
    // advances the model at the edge, returns at the next posedge+1.
    task automatic step(input bit we, input logic [4:0] rd, input logic [DW-1:0] d,
                        input bit mv, input logic [4:0] mrd, input logic [DW-1:0] md);
        RegWriteW_i = we; RdW_i = rd; ResultW_i = d;
        MduValid_i = mv; MduRd_i = mrd; MduData_i = md;
        #2;
        model_eval();
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    int n_force;

    initial begin
        rst_n = 1'b0;
        RegWriteW_i = 1; RdW_i = 5; ResultW_i = 32'hDEAD_BEEF;
        MduValid_i = 0; MduRd_i = 0; MduData_i = 0;
        model_reset();
        @(posedge clk); #1;
        model_eval();
        compare_all();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pipeline write passes straight through.
        step(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
        // MDU rd 7 with idle pipeline: written next cycle, mask for one cycle.
        step(0, 0, 0, 1, 7, 32'h1234);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Fill FIFO under continuous pipeline writes; forced drains.
        step(1, 1, 32'h11, 1, 3, 32'h333);
        step(1, 1, 32'h12, 1, 4, 32'h444);
        n_force = 0;
        for (int i = 0; i < 24; i++) begin
            if (Stall_o) n_force++;
            step(1, 1, 32'h100 + i, 0, 0, 0);
        end
        check("force_count", n_force, STARVE_EN ? 2 : 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Collision: buffered rd 9 killed by a pipeline write to x9.
        step(0, 0, 0, 1, 9, 32'h99);
        step(1, 9, 32'hAA, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // rd 0 on both sides.
        step(0, 0, 0, 1, 0, 32'h55);
        step(1, 0, 32'h66, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset with two entries buffered (during a forced drain if enabled).
        step(1, 2, 32'h21, 1, 12, 32'hC0);
        step(1, 2, 32'h22, 1, 13, 32'hD0);
        for (int i = 0; i < 30; i++) begin
            if (Stall_o) break;
            step(1, 2, 32'h30 + i, 0, 0, 0);
        end
        RegWriteW_i = 1; RdW_i = 5; ResultW_i = 32'h5A5A_0001;
        MduValid_i = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        model_eval();
        compare_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            model_eval();
            compare_all();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);

        // Random traffic with a small register range to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom);
        end
        // Quiet tail lets any buffered results drain and be checked.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
